// File: rtl/aux_sync_rx.sv
// Aux sync pulse-train receiver: synchronises sync_in, measures the edge-to-edge
// period and tracks lock against a programmable expected period over Wishbone.
module aux_sync_rx #(
  parameter int PERIOD     = 1024,
  parameter int TOLERANCE  = 2,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        sync_in,
  output logic        sync_pulse,
  output logic        locked
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              edge_det;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  expected;
  logic [CNT_W-1:0]  last_period;
  logic [MC_W-1:0]   match_cnt;
  logic [31:0]       edge_count;
  logic [31:0]       err_count;
  logic [CNT_W:0]    diff;
  logic [CNT_W:0]    limit;
  logic              match;
  logic              timeout;
  logic              err_event;
  logic              bus_req;
  logic              bus_wr;
  logic [2:0]        reg_sel;
  logic              clear_cnt;
  logic              force_unlock;
  logic [31:0]       byte_mask;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign wb_err_o = 1'b0;
  assign edge_det = s2 & ~s3;

  // Measured period is the counter value on the edge cycle; compare without wrap.
  assign diff    = (cnt >= expected) ? ({1'b0, cnt} - {1'b0, expected})
                                     : ({1'b0, expected} - {1'b0, cnt});
  assign match   = diff <= (CNT_W+1)'(TOLERANCE);
  assign limit   = {1'b0, expected} + (CNT_W+1)'(TOLERANCE);
  assign timeout = ({1'b0, cnt} > limit) && !edge_det;
  assign err_event = (state == LOCKED) && ((edge_det && !match) || timeout);

  // A request is only accepted when no ack is outstanding, so a held strobe
  // gets acknowledged every second cycle.
  assign bus_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign bus_wr       = bus_req & wb_we_i;
  assign reg_sel      = wb_adr_i[4:2];
  assign clear_cnt    = bus_wr && (reg_sel == 3'd5) && wb_dat_i[0];
  assign force_unlock = bus_wr && (reg_sel == 3'd5) && wb_dat_i[1];
  assign byte_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_bits  = ^{wb_adr_i, wb_dat_i, byte_mask};

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      3'd0:    rd_data = {29'd0, locked, state};
      3'd1:    rd_data = 32'(expected);
      3'd2:    rd_data = 32'(last_period);
      3'd3:    rd_data = edge_count;
      3'd4:    rd_data = err_count;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      expected <= CNT_W'(PERIOD);
    end else begin
      wb_ack_o <= bus_req;
      wb_dat_o <= bus_req ? rd_data : 32'd0;
      if (bus_wr && reg_sel == 3'd1)
        expected <= (expected & ~byte_mask[CNT_W-1:0]) | (wb_dat_i[CNT_W-1:0] & byte_mask[CNT_W-1:0]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= UNLOCKED;
      locked      <= 1'b0;
      match_cnt   <= '0;
      cnt         <= '0;
      last_period <= '0;
      edge_count  <= 32'd0;
      err_count   <= 32'd0;
      sync_pulse  <= 1'b0;
    end else begin
      sync_pulse <= edge_det;
      if (edge_det)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (edge_det && state != UNLOCKED)
        last_period <= cnt;
      if (edge_det)
        edge_count <= edge_count + 32'd1;
      if (err_event && err_count != 32'hFFFF_FFFF)
        err_count <= err_count + 32'd1;

      case (state)
        UNLOCKED: begin
          if (edge_det) begin
            state     <= ACQUIRE;
            match_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (edge_det) begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else if (timeout) begin
            state     <= UNLOCKED;
            match_cnt <= '0;
          end
        end
        LOCKED: begin
          if (edge_det && !match) begin
            state     <= ACQUIRE;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else if (timeout) begin
            state     <= UNLOCKED;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state     <= UNLOCKED;
          locked    <= 1'b0;
          match_cnt <= '0;
        end
      endcase

      // Bus control overrides whatever the pulse train did this cycle.
      if (clear_cnt) begin
        edge_count <= 32'd0;
        err_count  <= 32'd0;
      end
      if (force_unlock) begin
        state     <= UNLOCKED;
        locked    <= 1'b0;
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aux_sync_rx.sv
// Directed bench for aux_sync_rx: register map table plus hand-timed pulse
// trains for lock, error, timeout, byte-enable and CTRL-vs-edge cases.
module tb_aux_sync_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0;
  logic [31:0] datIn = 32'd0;
  logic [31:0] datOut;
  logic        ack;
  logic        err;
  logic        syncIn = 1'b0;
  logic        syncPulse;
  logic        locked;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int lastRise = 0;

  typedef struct {
    logic [2:0]  regIdx;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic [31:0] expRead;
    string       name;
  } vec_t;

  vec_t vecs[11];

  aux_sync_rx dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_adr_i   (adr),
    .wb_dat_i   (datIn),
    .wb_dat_o   (datOut),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .sync_in    (syncIn),
    .sync_pulse (syncPulse),
    .locked     (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int n);
    while (cycleCount < n) tick();
  endtask

  task automatic busCycle(input logic [2:0] idx, input logic wr, input logic [31:0] data,
                          input logic [3:0] s, output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'hDEAD_BEEF;
    adr = {27'd0, idx, 2'b00};
    we = wr;
    datIn = data;
    sel = s;
    cyc = 1'b1;
    stb = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        rdata = datOut;
      end
    end
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    checkOutput("ack", {31'd0, got}, 32'd1);
    checkOutput("wb_err", {31'd0, err}, 32'd0);
  endtask

  task automatic checkReg(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] rd;
    busCycle(idx, 1'b0, 32'd0, 4'hF, rd);
    checkOutput(name, rd, exp);
  endtask

  task automatic writeReg(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] s);
    logic [31:0] rd;
    busCycle(idx, 1'b1, data, s, rd);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    busCycle(v.regIdx, v.wr, v.wdata, v.wsel, rd);
    if (!v.wr) checkOutput(v.name, rd, v.expRead);
  endtask

  // Rising edge of sync_in placed at an absolute cycle so bus traffic in between
  // does not disturb the period; the registered pulse lands three cycles later.
  task automatic pulseAt(input int when);
    waitUntil(when);
    syncIn = 1'b1;
    lastRise = cycleCount;
    tick();
    tick();
    tick();
    checkOutput("sync_pulse_high", {31'd0, syncPulse}, 32'd1);
    tick();
    checkOutput("sync_pulse_low", {31'd0, syncPulse}, 32'd0);
    syncIn = 1'b0;
  endtask

  initial begin
    int ackCount;
    int r;
    logic [31:0] rd;

    vecs[0]  = '{3'd0, 1'b0, 32'd0,         4'hF, 32'd0,    "reset_status"};
    vecs[1]  = '{3'd1, 1'b0, 32'd0,         4'hF, 32'd1024, "reset_expected"};
    vecs[2]  = '{3'd2, 1'b0, 32'd0,         4'hF, 32'd0,    "reset_last_period"};
    vecs[3]  = '{3'd3, 1'b0, 32'd0,         4'hF, 32'd0,    "reset_edge_count"};
    vecs[4]  = '{3'd4, 1'b0, 32'd0,         4'hF, 32'd0,    "reset_err_count"};
    vecs[5]  = '{3'd5, 1'b0, 32'd0,         4'hF, 32'd0,    "ctrl_reads_zero"};
    vecs[6]  = '{3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0,    "write_reg6"};
    vecs[7]  = '{3'd6, 1'b0, 32'd0,         4'hF, 32'd0,    "reg6_reads_zero"};
    vecs[8]  = '{3'd7, 1'b0, 32'd0,         4'hF, 32'd0,    "reg7_reads_zero"};
    vecs[9]  = '{3'd0, 1'b1, 32'h0000_00FF, 4'hF, 32'd0,    "write_status"};
    vecs[10] = '{3'd0, 1'b0, 32'd0,         4'hF, 32'd0,    "status_ro"};

    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset_sync_pulse", {31'd0, syncPulse}, 32'd0);
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_ack", {31'd0, ack}, 32'd0);
    checkOutput("reset_dat_o", datOut, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Held strobe: acks on alternate cycles only.
    ackCount = 0;
    adr = 32'h4;
    we = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) ackCount++;
    end
    cyc = 1'b0;
    stb = 1'b0;
    tick();
    checkOutput("held_strobe_acks", ackCount, 32'd2);

    // Acquire and lock on a 1024-cycle train.
    pulseAt(cycleCount + 5);
    checkReg("status_after_first_edge", 3'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      pulseAt(lastRise + 1024);
      if (i == 2) checkReg("status_after_4th_edge", 3'd0, 32'd1);
    end
    checkOutput("locked_5th_edge", {31'd0, locked}, 32'd1);
    checkReg("status_locked", 3'd0, 32'd6);
    checkReg("last_period_1024", 3'd2, 32'd1024);
    checkReg("edge_count_5", 3'd3, 32'd5);

    // Long period: times out in LOCKED before the late edge arrives.
    pulseAt(lastRise + 1030);
    checkReg("err_after_1030", 3'd4, 32'd1);
    checkReg("status_after_1030", 3'd0, 32'd1);
    checkOutput("locked_after_1030", {31'd0, locked}, 32'd0);
    checkReg("last_period_kept", 3'd2, 32'd1024);
    for (int i = 0; i < 4; i++) pulseAt(lastRise + 1024);
    checkReg("status_relocked", 3'd0, 32'd6);
    pulseAt(lastRise + 1026);
    checkReg("err_after_1026", 3'd4, 32'd1);
    checkReg("status_after_1026", 3'd0, 32'd6);
    checkReg("last_period_1026", 3'd2, 32'd1026);

    // Pulses stop: cnt reaches 1027 in cycle R+1029, state drops at R+1030.
    r = lastRise;
    waitUntil(r + 1028);
    checkReg("status_before_timeout", 3'd0, 32'd6);
    checkOutput("locked_cnt_1027", {31'd0, locked}, 32'd1);
    tick();
    checkOutput("locked_after_timeout", {31'd0, locked}, 32'd0);
    checkReg("status_after_timeout", 3'd0, 32'd0);
    checkReg("err_after_timeout", 3'd4, 32'd2);

    // Byte enables on EXPECTED.
    writeReg(3'd1, 32'd0, 4'hF);
    checkReg("expected_cleared", 3'd1, 32'd0);
    writeReg(3'd1, 32'h200, 4'b0001);
    checkReg("expected_sel_0001", 3'd1, 32'h000);
    writeReg(3'd1, 32'h200, 4'b0011);
    checkReg("expected_sel_0011", 3'd1, 32'h200);

    pulseAt(cycleCount + 2);
    for (int i = 0; i < 4; i++) pulseAt(lastRise + 512);
    checkReg("status_locked_512", 3'd0, 32'd6);
    checkReg("last_period_512", 3'd2, 32'd512);
    checkReg("edge_count_16", 3'd3, 32'd16);

    // CTRL clear+force issued in the same cycle the edge is detected.
    r = lastRise + 512;
    waitUntil(r);
    syncIn = 1'b1;
    lastRise = cycleCount;
    tick();
    tick();
    writeReg(3'd5, 32'd3, 4'hF);
    tick();
    syncIn = 1'b0;
    checkReg("edge_count_cleared", 3'd3, 32'd0);
    checkReg("err_count_cleared", 3'd4, 32'd0);
    checkReg("status_forced", 3'd0, 32'd0);
    checkOutput("locked_forced", {31'd0, locked}, 32'd0);

    // Reset during a bus cycle drops the ack and restores EXPECTED.
    adr = 32'h4;
    cyc = 1'b1;
    stb = 1'b1;
    rst = 1'b1;
    tick();
    checkOutput("ack_dropped_in_reset", {31'd0, ack}, 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    tick();
    rst = 1'b0;
    checkReg("expected_after_reset", 3'd1, 32'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aux_sync_rx.md
# aux_sync_rx

Wishbone slave that receives the inter-board aux sync pulse train (the input counterpart of the periodic aux sync output), measures the period between pulses, and reports lock against a programmable expected period. Sits on the EPB-to-Wishbone slave bus alongside the sys block and GPIO controllers, clocked by the bus clock. The buffered aux_synci is the input; its synchronised, edge-qualified pulse is exported to user logic.

## Interface
- PERIOD, 1024: reset value of the EXPECTED register, in wb_clk_i cycles.
- TOLERANCE, 2: allowed ± deviation of a measured period from EXPECTED.
- LOCK_COUNT, 4: consecutive in-tolerance periods required to lock.
- CNT_W, 16: period counter width; counter saturates at 2^CNT_W-1.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone slave controls.
- wb_sel_i  in  4  byte enables (honoured on EXPECTED writes only).
- wb_adr_i  in  32  byte address; wb_adr_i[4:2] selects register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  tied 0.
- sync_in  in  1  asynchronous aux sync from the differential input buffer.
- sync_pulse  out  1  one-cycle pulse per detected rising edge.
- locked  out  1  high while in LOCKED.

## Operation
- sync_in passes through two flops (s1, s2), then a third flop s3; edge = s2 & !s3.
- Period counter cnt: on edge cycle, meas = cnt, then cnt <= 1; otherwise cnt <= cnt+1, saturating. Edges every P cycles give meas = P.
- match = |meas - EXPECTED| <= TOLERANCE (compare in CNT_W+1 bits, no wrap).
- timeout = (cnt > EXPECTED + TOLERANCE) with no edge this cycle.
- States: UNLOCKED=0, ACQUIRE=1, LOCKED=2.
  - UNLOCKED: edge -> ACQUIRE, match_cnt=0 (first period invalid, LAST_PERIOD not updated).
  - ACQUIRE: edge & match -> match_cnt+1; reaching LOCK_COUNT -> LOCKED. edge & !match -> match_cnt=0, stay. timeout -> UNLOCKED.
  - LOCKED: edge & match -> stay. edge & !match -> ERR+1, ACQUIRE, match_cnt=0. timeout -> ERR+1, UNLOCKED.
- LAST_PERIOD <= meas on every edge outside UNLOCKED. EDGE_COUNT +1 every edge (32-bit, wraps). ERR_COUNT 32-bit, saturates at 0xFFFFFFFF.
- Registers (wb_adr_i[4:2]): 0 STATUS RO {29'b0, locked, state[1:0]}; 1 EXPECTED RW, CNT_W bits zero-extended; 2 LAST_PERIOD RO; 3 EDGE_COUNT RO; 4 ERR_COUNT RO; 5 CTRL WO (reads 0): bit0 clear EDGE/ERR counts, bit1 force UNLOCKED. 6-7 read 0, writes ignored.
- Writing EXPECTED takes effect for the next comparison; state is not reset.
- CTRL clear/force coinciding with an edge: CTRL wins (counts 0, state UNLOCKED).

## Timing
- Reset values: wb_ack_o 0, wb_dat_o 0, sync_pulse 0, locked 0, state UNLOCKED, cnt 0, match_cnt 0, LAST_PERIOD 0, EDGE_COUNT 0, ERR_COUNT 0, EXPECTED PERIOD, s1..s3 0.
- sync_in rising (settled before edge k) -> edge combinational in cycle k+2; sync_pulse, state, counters registered at k+3.
- locked is registered from state; asserts the cycle state becomes LOCKED.
- Wishbone: cyc&stb at cycle n -> ack at n+1 for one cycle, data valid with ack; ack forced 0 the cycle after an ack (no back-to-back), so a held strobe yields acks every second cycle. Write side effects occur on the ack cycle.
- Reset mid-operation clears everything within one cycle; an in-flight bus cycle is dropped (no ack).

## Test plan
- Reset, then read all registers -> STATUS 0, EXPECTED 1024, others 0; wb_err_o 0 throughout.
- Pulses every 1024 cycles -> ACQUIRE after first edge, locked high on 5th edge (4 matching periods), LAST_PERIOD 1024, EDGE_COUNT 5.
- While locked, one period 1030 -> ERR_COUNT 1, state ACQUIRE, relocks after 4 more good periods; period 1026 (within ±2) -> no error.
- While locked, stop pulses -> at cnt 1027 state UNLOCKED, locked 0, ERR_COUNT +1.
- Write EXPECTED=512 with wb_sel_i=4'b0001 -> reads 0x000; with 4'b0011 -> 0x200; 512-cycle train then locks.
- Write CTRL=3 on the same cycle as a sync edge -> EDGE_COUNT 0, ERR_COUNT 0, state UNLOCKED.
